// File: rtl/mux21_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux21_pkg
// Description : Shared types and default constants for the 2:1 mux input
//               conditioner (FSM state encoding, synchronizer and debounce
//               defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package mux21_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mux21_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/mux21_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : mux21_sync_debounce
// Description : Multi-flop synchronizer followed by a debouncer and a
//               rising-edge detector for a bouncy push-button.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ena_i     in   enable; low holds the debouncer (synchronizer keeps running)
//   d_raw_i   in   raw asynchronous button
//   press_o   out  one-cycle pulse on an accepted rising button level
// Revision    : 1.0 - initial release
// ============================================================================
module mux21_sync_debounce
    import mux21_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic d_raw_i,
    output logic press_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   prev_q, prev_d;
    logic                   w_sync;

    // Synchronizer always samples, even while the tile is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw_i};
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    // The counter measures how long the synchronized input has persisted at
    // a level different from the accepted one; any return to the accepted
    // level restarts the measurement, so short bounces are never accepted.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        prev_d  = prev_q;
        if (ena_i) begin
            prev_d = level_q;
            if (w_sync != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_d = w_sync;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    // prev_q only advances on enabled cycles, so a press that coincides with
    // ena dropping is held and consumed once the tile resumes.
    assign press_o = level_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/mux21_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : mux21_input_conditioner
// Description : Upstream stage of the 2:1 mux tile. Synchronizes raw pad
//               inputs, debounces the select button and generates sel either
//               manually (button toggles) or automatically (period toggle).
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   ena            in   tile enable; low freezes state, outputs hold
//   btn_raw        in   raw select push-button
//   in1_raw        in   raw data input 1
//   in2_raw        in   raw data input 2
//   mode_auto_raw  in   raw mode strap (1 = auto, 0 = manual)
//   period         in   auto-toggle period in cycles
//   sel            out  registered select
//   in1, in2       out  registered data
//   sel_toggled    out  pulse aligned with each new sel value
//   auto_active    out  high while in AUTO
//   toggle_count   out  8-bit wrapping toggle count (only with macro
//                       MUX21_COND_TOGGLE_COUNT_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
module mux21_input_conditioner
    import mux21_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PERIOD_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                btn_raw,
    input  logic                in1_raw,
    input  logic                in2_raw,
    input  logic                mode_auto_raw,
    input  logic [PERIOD_W-1:0] period,
    output logic                sel,
    output logic                in1,
    output logic                in2,
    output logic                sel_toggled,
    output logic                auto_active
`ifdef MUX21_COND_TOGGLE_COUNT_EN
    ,
    output logic [7:0]          toggle_count
`endif
);

    // Bit 0 = in1, bit 1 = in2, bit 2 = mode strap.
    logic [SYNC_STAGES-1:0][2:0] dsync_q;
    logic [2:0]                  w_dsync;
    logic                        w_btn_press;

    mux21_state_e                state_q, state_d;
    logic [PERIOD_W-1:0]         pcnt_q, pcnt_d;
    logic                        sel_q, sel_d;
    logic                        in1_q, in2_q;
    logic                        sel_toggled_q;
    logic                        w_toggle;

    mux21_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .d_raw_i (btn_raw),
        .press_o (w_btn_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsync_q <= '0;
        end else begin
            dsync_q <= {dsync_q[SYNC_STAGES-2:0], {mode_auto_raw, in2_raw, in1_raw}};
        end
    end

    assign w_dsync = dsync_q[SYNC_STAGES-1];

    // Toggle decision follows the current state's rule; a mode change seen in
    // the same cycle only affects the state from the next cycle on.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        w_toggle = 1'b0;
        if (ena) begin
            case (state_q)
                MANUAL: begin
                    w_toggle = w_btn_press;
                    pcnt_d   = '0;       // counter starts from 0 on AUTO entry
                    if (w_dsync[2]) begin
                        state_d = AUTO;
                    end
                end
                AUTO: begin
                    if (period == '0) begin
                        pcnt_d = '0;
                    end else if (pcnt_q >= period - PERIOD_W'(1)) begin
                        // ">=" lets a shrunken period wrap at once instead of
                        // running the counter out through its full range.
                        w_toggle = 1'b1;
                        pcnt_d   = '0;
                    end else begin
                        pcnt_d = pcnt_q + PERIOD_W'(1);
                    end
                    if (!w_dsync[2]) begin
                        state_d = MANUAL;
                    end
                end
                default: state_d = MANUAL;
            endcase
        end
        sel_d = sel_q ^ w_toggle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MANUAL;
            pcnt_q        <= '0;
            sel_q         <= 1'b0;
            in1_q         <= 1'b0;
            in2_q         <= 1'b0;
            sel_toggled_q <= 1'b0;
        end else begin
            // w_toggle is already gated by ena, so this clears while disabled.
            sel_toggled_q <= w_toggle;
            if (ena) begin
                state_q <= state_d;
                pcnt_q  <= pcnt_d;
                sel_q   <= sel_d;
                in1_q   <= w_dsync[0];
                in2_q   <= w_dsync[1];
            end
        end
    end

    assign sel         = sel_q;
    assign in1         = in1_q;
    assign in2         = in2_q;
    assign sel_toggled = sel_toggled_q;
    assign auto_active = (state_q == AUTO);

`ifdef MUX21_COND_TOGGLE_COUNT_EN
    logic [7:0] tcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (w_toggle) begin
            tcnt_q <= tcnt_q + 8'd1;
        end
    end

    assign toggle_count = tcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux21_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux21_input_conditioner
// Description : Self-checking bench for mux21_input_conditioner (default
//               parameters). Toggle-counter checks are built only when
//               MUX21_COND_TOGGLE_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux21_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       btn_raw = 1'b0;
    logic       in1_raw = 1'b0;
    logic       in2_raw = 1'b0;
    logic       mode_auto_raw = 1'b0;
    logic [7:0] period = 8'd0;
    logic       sel, in1, in2, sel_toggled, auto_active;
`ifdef MUX21_COND_TOGGLE_COUNT_EN
    logic [7:0] toggle_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_sel = 1'b0;

    typedef struct packed {
        logic sel;
        logic tog;
        logic in1;
        logic in2;
    } exp_t;
    exp_t sb_q[$];

    mux21_input_conditioner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .btn_raw       (btn_raw),
        .in1_raw       (in1_raw),
        .in2_raw       (in2_raw),
        .mode_auto_raw (mode_auto_raw),
        .period        (period),
        .sel           (sel),
        .in1           (in1),
        .in2           (in2),
        .sel_toggled   (sel_toggled),
        .auto_active   (auto_active)
`ifdef MUX21_COND_TOGGLE_COUNT_EN
        ,
        .toggle_count  (toggle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_auto(input logic want, input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (auto_active === want) break;
            tick();
        end
        n_tests++;
        if (auto_active !== want) begin
            n_fail++;
            $display("FAIL %s: auto_active=%b required %b within 20 cycles", name, auto_active, want);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sel, in1, in2, sel_toggled, auto_active} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_init: outputs=%b required 00000", {sel, in1, in2, sel_toggled, auto_active});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({sel, auto_active} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_release: sel,auto=%b required 00", {sel, auto_active});
        end
        exp_sel = 1'b0;
    endtask

    task automatic test_data_latency();
        exp_t e;
        in1_raw = 1'b1;
        sb_q.push_back('{exp_sel, 1'b0, 1'b0, 1'b0});
        sb_q.push_back('{exp_sel, 1'b0, 1'b0, 1'b0});
        sb_q.push_back('{exp_sel, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                in1_raw = 1'b0;
                in2_raw = 1'b1;
            end
            e = sb_q.pop_front();
            n_tests++;
            if ({sel, in1, in2} !== {e.sel, e.in1, e.in2}) begin
                n_fail++;
                $display("FAIL latency_in1 cyc%0d: sel,in1,in2=%b required %b", k + 1, {sel, in1, in2}, {e.sel, e.in1, e.in2});
            end
        end
        // in1 fell and in2 rose one cycle after the first change.
        sb_q.push_back('{exp_sel, 1'b0, 1'b0, 1'b1});
        tick();
        e = sb_q.pop_front();
        n_tests++;
        if ({sel, in1, in2} !== {e.sel, e.in1, e.in2}) begin
            n_fail++;
            $display("FAIL latency_in2: sel,in1,in2=%b required %b", {sel, in1, in2}, {e.sel, e.in1, e.in2});
        end
        in2_raw = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_bounce();
        int   len[4] = '{5, 3, 5, 30};
        logic lvl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   pulses;
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                btn_raw = lvl[s];
                sb_q.push_back('{exp_sel, 1'b0, 1'b0, 1'b0});
                tick();
                e = sb_q.pop_front();
                n_tests++;
                if ({sel, sel_toggled} !== {e.sel, e.tog}) begin
                    n_fail++;
                    $display("FAIL bounce_reject seg%0d: sel,tog=%b required %b", s, {sel, sel_toggled}, {e.sel, e.tog});
                end
            end
        end
        btn_raw = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || sel !== ~exp_sel) begin
            n_fail++;
            $display("FAIL bounce_accept: pulses=%0d sel=%b required 1 and %b", pulses, sel, ~exp_sel);
        end
        exp_sel = ~exp_sel;
        btn_raw = 1'b0;
        pulses = 0;
        repeat (30) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || sel !== exp_sel) begin
            n_fail++;
            $display("FAIL bounce_release: pulses=%0d sel=%b required 0 and %b", pulses, sel, exp_sel);
        end
    endtask

    task automatic test_reset_midrun();
        int pulses;
        n_tests++;
        if (sel !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: sel=%b required 1", sel);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sel, in1, in2, sel_toggled, auto_active} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%b required 00000", {sel, in1, in2, sel_toggled, auto_active});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({sel, auto_active} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: sel,auto=%b required 00", {sel, auto_active});
        end
        exp_sel = 1'b0;
        // First press after reset must go through the whole debounce.
        btn_raw = 1'b1;
        pulses = 0;
        repeat (10) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || sel !== exp_sel) begin
            n_fail++;
            $display("FAIL reset_full_debounce: pulses=%0d sel=%b required 0 and %b", pulses, sel, exp_sel);
        end
        repeat (30) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || sel !== ~exp_sel) begin
            n_fail++;
            $display("FAIL reset_first_press: pulses=%0d sel=%b required 1 and %b", pulses, sel, ~exp_sel);
        end
        exp_sel = ~exp_sel;
        btn_raw = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_auto();
        exp_t e;
        period = 8'd4;
        mode_auto_raw = 1'b1;
        wait_auto(1'b1, "auto_enter");
        n_tests++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL auto_entry_sel: sel=%b required %b", sel, exp_sel);
        end
        for (int k = 1; k <= 16; k++) begin
            sb_q.push_back('{exp_sel ^ (((k / 4) % 2) == 1), (k % 4) == 0, 1'b0, 1'b0});
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if ({sel, sel_toggled} !== {e.sel, e.tog}) begin
                n_fail++;
                $display("FAIL auto_p4 k%0d: sel,tog=%b required %b", k, {sel, sel_toggled}, {e.sel, e.tog});
            end
        end
        period = 8'd0;
        for (int k = 0; k < 12; k++) begin
            sb_q.push_back('{exp_sel, 1'b0, 1'b0, 1'b0});
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if ({sel, sel_toggled} !== {e.sel, e.tog}) begin
                n_fail++;
                $display("FAIL auto_p0 k%0d: sel,tog=%b required %b", k, {sel, sel_toggled}, {e.sel, e.tog});
            end
        end
    endtask

    task automatic test_mode_ena();
        logic m_sel;
        logic m_tog;
        int   m_cnt;
        int   pulses;
        exp_t e;
        m_sel = exp_sel;
        m_cnt = 0;
        period = 8'd3;
        for (int i = 0; i < 110; i++) begin
            ena     = !(i >= 5 && i < 15);
            if (i == 30) period = 8'd0;
            btn_raw = (i >= 30 && i < 70);
            m_tog = 1'b0;
            if (ena) begin
                if (period == 8'd0) begin
                    m_cnt = 0;
                end else if (m_cnt >= int'(period) - 1) begin
                    m_sel = ~m_sel;
                    m_tog = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            sb_q.push_back('{m_sel, m_tog, 1'b0, 1'b0});
            tick();
            e = sb_q.pop_front();
            n_tests++;
            if ({sel, sel_toggled} !== {e.sel, e.tog}) begin
                n_fail++;
                $display("FAIL mode_ena i%0d: sel,tog=%b required %b", i, {sel, sel_toggled}, {e.sel, e.tog});
            end
        end
        ena = 1'b1;
        btn_raw = 1'b0;
        exp_sel = m_sel;
        mode_auto_raw = 1'b0;
        wait_auto(1'b0, "manual_enter");
        n_tests++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL manual_keeps_sel: sel=%b required %b", sel, exp_sel);
        end
        btn_raw = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || sel !== ~exp_sel) begin
            n_fail++;
            $display("FAIL manual_press: pulses=%0d sel=%b required 1 and %b", pulses, sel, ~exp_sel);
        end
        exp_sel = ~exp_sel;
        btn_raw = 1'b0;
        repeat (30) tick();
    endtask

`ifdef MUX21_COND_TOGGLE_COUNT_EN
    task automatic test_toggle_count();
        int pulses;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (toggle_count !== 8'd0) begin
            n_fail++;
            $display("FAIL tcount_reset: toggle_count=%0d required 0", toggle_count);
        end
        period = 8'd1;
        mode_auto_raw = 1'b1;
        wait_auto(1'b1, "tcount_auto_enter");
        pulses = 0;
        repeat (260) begin
            tick();
            if (sel_toggled === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 260 || toggle_count !== 8'd4) begin
            n_fail++;
            $display("FAIL tcount_wrap: pulses=%0d toggle_count=%0d required 260 and 4", pulses, toggle_count);
        end
        mode_auto_raw = 1'b0;
        period = 8'd0;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_data_latency();
        test_bounce();
        test_reset_midrun();
        test_auto();
        test_mode_ena();
`ifdef MUX21_COND_TOGGLE_COUNT_EN
        test_toggle_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
